irq_controller: RTL and testbench

//  Interrupt controller directly upstream of the special-register block: it collects NUM_IRQ

---
 rtl/irq_controller.sv | 146 ++++++++++++++
 tb/tb_irq_controller.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// Edge/level interrupt collector with mask, fixed priority and sregs handshake.
// Define IRQ_SYNC_EN to put a 2-flop synchroniser in front of edge detection.
module irq_controller #(
   parameter int NUM_IRQ = 8,
   parameter logic [NUM_IRQ-1:0] EDGE_MASK = {NUM_IRQ{1'b1}}
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_IRQ-1:0] irq_lines,
   input  logic               irq_en,
   input  logic               irq_ack,
   output logic               irq_out,
   output logic [3:0]         irq_cause,
   input  logic [1:0]         reg_addr,
   input  logic               reg_we,
   input  logic [15:0]        reg_wdata,
   output logic [15:0]        reg_rdata
);

   // Internals are 16 wide; bits above NUM_IRQ are tied off by VALID.
   localparam logic [15:0] VALID = 16'((17'd1 << NUM_IRQ) - 17'd1);
   localparam logic [15:0] EDGE  = 16'(EDGE_MASK) & VALID;

   typedef enum logic [1:0] {IDLE, REQ, WAIT_DIS} state_t;

   state_t      state;
   logic        cause_valid;
   logic [15:0] pending;
   logic [15:0] mask;
   logic [15:0] s;
   logic [15:0] s_prev;
   logic [15:0] rise;
   logic [15:0] w1c;
   logic [15:0] swi;
   logic [15:0] ack_clr;
   logic [15:0] pend_nxt;
   logic [15:0] active;
   logic [3:0]  sel;
   logic        ack_ok;

`ifdef IRQ_SYNC_EN
   logic [15:0] sync0;
   logic [15:0] sync1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync0 <= '0;
         sync1 <= '0;
      end else begin
         sync0 <= 16'(irq_lines) & VALID;
         sync1 <= sync0;
      end
   end

   assign s = sync1;
`else
   assign s = 16'(irq_lines) & VALID;
`endif

   assign ack_ok = (state == REQ) && irq_ack;
   assign active = pending & mask;

   always_comb begin
      rise    = s & ~s_prev;
      w1c     = '0;
      swi     = '0;
      ack_clr = '0;
      if (reg_we && reg_addr == 2'd0)
         w1c = reg_wdata;
      if (reg_we && reg_addr == 2'd3)
         swi = reg_wdata;
      for (int i = 0; i < 16; i++)
         if (ack_ok && irq_cause == 4'(i))
            ack_clr[i] = 1'b1;
      // Sets are OR-ed in after clears so a coincident edge survives.
      pend_nxt = (EDGE & (((pending & ~(w1c | ack_clr)) | rise | swi)))
               | (~EDGE & s);
   end

   always_comb begin
      sel = 4'd0;
      for (int i = 15; i >= 0; i--)
         if (active[i])
            sel = 4'(i);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_prev  <= '0;
         pending <= '0;
         mask    <= '0;
      end else begin
         s_prev  <= s;
         pending <= pend_nxt & VALID;
         if (reg_we && reg_addr == 2'd1)
            mask <= reg_wdata & VALID;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         irq_out     <= 1'b0;
         irq_cause   <= 4'd0;
         cause_valid <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (irq_en && |active) begin
                  irq_cause   <= sel;
                  cause_valid <= 1'b1;
                  irq_out     <= 1'b1;
                  state       <= REQ;
               end
            end
            REQ: begin
               if (irq_ack) begin
                  irq_out <= 1'b0;
                  state   <= WAIT_DIS;
               end else if (!irq_en) begin
                  irq_out     <= 1'b0;
                  cause_valid <= 1'b0;
                  state       <= IDLE;
               end
            end
            WAIT_DIS: begin
               if (!irq_en)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      reg_rdata = '0;
      unique case (reg_addr)
         2'd0: reg_rdata = pending;
         2'd1: reg_rdata = mask;
         2'd2: reg_rdata = {cause_valid, 11'b0, irq_cause};
         2'd3: reg_rdata = '0;
         default: reg_rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller; line 3 is level type, the rest edge.
// Expected values are hand-computed per step.
module tb_irq_controller;

`ifdef IRQ_SYNC_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 2;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  irq_lines;
   logic        irq_en;
   logic        irq_ack;
   logic        irq_out;
   logic [3:0]  irq_cause;
   logic [1:0]  reg_addr;
   logic        reg_we;
   logic [15:0] reg_wdata;
   logic [15:0] reg_rdata;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   irq_controller #(
      .NUM_IRQ   (8),
      .EDGE_MASK (8'hF7)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .irq_lines (irq_lines),
      .irq_en    (irq_en),
      .irq_ack   (irq_ack),
      .irq_out   (irq_out),
      .irq_cause (irq_cause),
      .reg_addr  (reg_addr),
      .reg_we    (reg_we),
      .reg_wdata (reg_wdata),
      .reg_rdata (reg_rdata)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic rd(input string tag, input logic [1:0] a,
                     input logic [15:0] exp);
      reg_addr = a;
      #1;
      chk(tag, reg_rdata, exp);
   endtask

   task automatic wr(input logic [1:0] a, input logic [15:0] d);
      reg_addr  = a;
      reg_wdata = d;
      reg_we    = 1'b1;
      step();
      reg_we    = 1'b0;
   endtask

   task automatic ack();
      irq_ack = 1'b1;
      step();
      irq_ack = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      irq_lines = '0;
      irq_en = 1'b0;
      irq_ack = 1'b0;
      reg_addr = '0;
      reg_we = 1'b0;
      reg_wdata = '0;
      repeat (2) step();
      chk("rst_irq_out", 16'(irq_out), 16'h0);
      chk("rst_cause", 16'(irq_cause), 16'h0);
      rd("rst_pending", 2'd0, 16'h0000);
      rd("rst_mask", 2'd1, 16'h0000);
      rd("rst_cause_reg", 2'd2, 16'h0000);
      rst = 1'b0;
      step();

      // 1: single edge on line 0
      wr(2'd1, 16'h0001);
      irq_en = 1'b1;
      irq_lines = 8'h01;
      repeat (LAT - 1) step();
      chk("t1_early", 16'(irq_out), 16'h0);
      step();
      chk("t1_irq_out", 16'(irq_out), 16'h1);
      chk("t1_cause", 16'(irq_cause), 16'h0);
      rd("t1_cause_reg", 2'd2, 16'h8000);
      irq_lines = 8'h00;
      ack();
      chk("t1_ack_out", 16'(irq_out), 16'h0);
      rd("t1_ack_pend", 2'd0, 16'h0000);
      irq_en = 1'b0;
      step();

      // 2: lines 5 and 2 together, priority
      wr(2'd1, 16'h00FF);
      irq_lines = 8'h24;
      repeat (LAT) step();
      rd("t2_pending", 2'd0, 16'h0024);
      chk("t2_no_req_en0", 16'(irq_out), 16'h0);
      irq_en = 1'b1;
      step();
      chk("t2_irq_out", 16'(irq_out), 16'h1);
      chk("t2_cause", 16'(irq_cause), 16'h2);
      irq_lines = 8'h00;

      // 3: ack then WAIT_DIS holds off line 5
      ack();
      chk("t3_ack_out", 16'(irq_out), 16'h0);
      rd("t3_pend", 2'd0, 16'h0020);
      repeat (3) step();
      chk("t3_wait_dis", 16'(irq_out), 16'h0);
      irq_en = 1'b0;
      step();
      irq_en = 1'b1;
      step();
      chk("t2_second_out", 16'(irq_out), 16'h1);
      chk("t2_second_cause", 16'(irq_cause), 16'h5);
      ack();
      irq_en = 1'b0;
      step();
      rd("t3_pend_empty", 2'd0, 16'h0000);

      // 4: level line 3
      irq_lines = 8'h08;
      repeat (LAT) step();
      rd("t4_pend", 2'd0, 16'h0008);
      wr(2'd0, 16'h0008);
      rd("t4_w1c_noeff", 2'd0, 16'h0008);
      irq_en = 1'b1;
      step();
      chk("t4_irq_out", 16'(irq_out), 16'h1);
      chk("t4_cause", 16'(irq_cause), 16'h3);
      ack();
      chk("t4_ack_out", 16'(irq_out), 16'h0);
      rd("t4_pend_ack", 2'd0, 16'h0008);
      irq_en = 1'b0;
      step();
      irq_en = 1'b1;
      step();
      chk("t4_rereq", 16'(irq_out), 16'h1);
      chk("t4_rereq_cause", 16'(irq_cause), 16'h3);
      irq_lines = 8'h00;
      irq_en = 1'b0;
      step();
      chk("t4_swdis_out", 16'(irq_out), 16'h0);
      rd("t4_swdis_cause", 2'd2, 16'h0003);
      repeat (LAT) step();
      rd("t4_level_low", 2'd0, 16'h0000);

      // 5: edge coincident with W1C, then SWI
      irq_lines = 8'h02;
      repeat (LAT - 2) step();
      wr(2'd0, 16'h0002);
      rd("t5_edge_wins", 2'd0, 16'h0002);
      wr(2'd3, 16'h0010);
      rd("t5_swi", 2'd0, 16'h0012);
      rd("t5_swi_read", 2'd3, 16'h0000);
      wr(2'd0, 16'h0012);
      rd("t5_w1c", 2'd0, 16'h0000);
      irq_lines = 8'h00;

      // 6: software disable in REQ, then reset mid-REQ
      wr(2'd3, 16'h0040);
      irq_en = 1'b1;
      step();
      chk("t6_irq_out", 16'(irq_out), 16'h1);
      rd("t6_cause_reg", 2'd2, 16'h8006);
      irq_en = 1'b0;
      step();
      chk("t6_dis_out", 16'(irq_out), 16'h0);
      rd("t6_dis_cause", 2'd2, 16'h0006);
      rd("t6_dis_pend", 2'd0, 16'h0040);
      irq_en = 1'b1;
      step();
      chk("t6_req_again", 16'(irq_out), 16'h1);
      rst = 1'b1;
      #1;
      chk("t6_rst_out", 16'(irq_out), 16'h0);
      chk("t6_rst_cause", 16'(irq_cause), 16'h0);
      rd("t6_rst_pend", 2'd0, 16'h0000);
      rd("t6_rst_mask", 2'd1, 16'h0000);
      rd("t6_rst_cause_reg", 2'd2, 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
